sprite_vblank_commit: RTL

Tear-free update controller for the 2-sprite engine. CPU writes to sprite registers (x, y, bitmap halves) are queued in a small FIFO instead of hitting the live registers. The queue drains in order into the sprite register file only during vertical blanking. One write-strobe port replaces direct bus writes to the sprite registers, so the CPU never has to stop the stream to reconfigure.

---
 rtl/sprite_commit_pkg.sv | 22 ++
 rtl/sprite_commit_fifo.sv | 62 ++++++
 rtl/sprite_vblank_commit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sprite_commit_pkg.sv
// rtl/sprite_commit_pkg.sv - shared state type, register selects and defaults for the sprite commit block
package sprite_commit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } commit_state_t;

    localparam logic [2:0] SEL_SPR0_X      = 3'd0;
    localparam logic [2:0] SEL_SPR0_Y      = 3'd1;
    localparam logic [2:0] SEL_SPR0_BMP_LO = 3'd2;
    localparam logic [2:0] SEL_SPR0_BMP_HI = 3'd3;
    localparam logic [2:0] SEL_SPR1_X      = 3'd4;
    localparam logic [2:0] SEL_SPR1_Y      = 3'd5;
    localparam logic [2:0] SEL_SPR1_BMP_LO = 3'd6;
    localparam logic [2:0] SEL_SPR1_BMP_HI = 3'd7;

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_DW    = 32;

endpackage

// File: rtl/sprite_commit_fifo.sv
// rtl/sprite_commit_fifo.sv - synchronous FIFO of {sel, data} updates with occupancy, full and empty
module sprite_commit_fifo
    import sprite_commit_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int W     = DEFAULT_DW + 3,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    // A full FIFO refuses a push even when the head leaves in the same cycle.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_vblank_commit.sv
// rtl/sprite_vblank_commit.sv - queues sprite register updates and commits them only during vertical blanking
// Optional frame counter enabled by SPRITE_COMMIT_FRAMECNT_EN.
module sprite_vblank_commit
    import sprite_commit_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int DW    = DEFAULT_DW,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [2:0]    wr_sel,
    input  logic [DW-1:0] wr_data,
    input  logic          vblank_start,
    input  logic          vblank,
    input  logic          commit_en,
    input  logic          flag_clr,
    output logic          cmt_valid,
    output logic [2:0]    cmt_sel,
    output logic [DW-1:0] cmt_data,
    output logic [LW-1:0] level,
    output logic          overflow,
    output logic          late,
    output logic          done_pulse,
    output logic [7:0]    frame_cnt
);

    commit_state_t state_q;
    commit_state_t state_d;

    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push_fire;
    logic          set_late;
    logic [DW+2:0] head;

    assign wr_ready   = !fifo_full;
    assign push_fire  = wr_valid && !fifo_full;
    assign done_pulse = (state_q == DONE);

    sprite_commit_fifo #(
        .DEPTH (DEPTH),
        .W     (DW + 3),
        .LW    (LW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_valid),
        .push_data ({wr_sel, wr_data}),
        .pop       (fifo_pop),
        .pop_data  (head),
        .level     (level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        set_late = 1'b0;
        case (state_q)
            IDLE: begin
                if (vblank_start && commit_en) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!commit_en) begin
                    state_d = IDLE;
                end else if (!vblank) begin
                    state_d  = IDLE;
                    set_late = !fifo_empty;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                end else if (!push_fire) begin
                    // An entry arriving into an empty queue keeps the drain open for it.
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cmt_valid <= 1'b0;
            cmt_sel   <= '0;
            cmt_data  <= '0;
        end else begin
            state_q   <= state_d;
            cmt_valid <= fifo_pop;
            if (fifo_pop) begin
                cmt_sel  <= head[DW+2:DW];
                cmt_data <= head[DW-1:0];
            end
        end
    end

    // Setting a sticky flag wins over clearing it in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            late     <= 1'b0;
        end else begin
            if (wr_valid && fifo_full) begin
                overflow <= 1'b1;
            end else if (flag_clr) begin
                overflow <= 1'b0;
            end
            if (set_late) begin
                late <= 1'b1;
            end else if (flag_clr) begin
                late <= 1'b0;
            end
        end
    end

`ifdef SPRITE_COMMIT_FRAMECNT_EN
    logic [7:0] frame_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= '0;
        end else if (vblank_start) begin
            frame_q <= frame_q + 8'd1;
        end
    end

    assign frame_cnt = frame_q;
`else
    assign frame_cnt = 8'd0;
`endif

endmodule
